// File: rtl/gray_stream_decoder_if.sv
// Stream bundle for the Gray-code decoder: sample input handshake,
// decoded output handshake and the status outputs that travel with it.
interface gray_stream_decoder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_gray;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             step_err;
  logic             dir;
  logic             locked;
  logic [7:0]       err_count;

  // Producer/consumer side: drives samples and the downstream accept.
  modport master (
    output in_valid, in_gray, out_ready,
    input  in_ready, out_valid, out_bin, step_err, dir, locked, err_count
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_gray, out_ready,
    output in_ready, out_valid, out_bin, step_err, dir, locked, err_count
  );
endinterface

// File: rtl/gray_stream_decoder.sv
// Gray-code stream decoder. Converts each accepted Gray sample to binary
// with one cycle of latency, checks that consecutive samples differ in
// exactly one bit, reports the count direction, and tracks lock through
// an EMPTY/RESYNC/TRACK state machine. Illegal steps are counted in a
// saturating 8-bit counter.
module gray_stream_decoder #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_stream_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_RESYNC = 2'd1,
    ST_TRACK  = 2'd2
  } state_e;

  // Gray to binary: MSB passes through, each lower bit folds in the
  // already-decoded bit above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of set bits; used as the Hamming distance between two codes.
  function automatic logic [4:0] popcount(input logic [WIDTH-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic             good_q, good_d;        // one legal step already seen in RESYNC
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  logic             step_err_q, step_err_d;
  logic             dir_q, dir_d;
  logic [7:0]       err_count_q, err_count_d;

  logic             accept;
  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] prev_inc;
  logic             legal;
  logic             up;

  // Output slot frees up when empty or when downstream takes the result.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign new_bin  = gray2bin(bus.in_gray);
  assign prev_bin = gray2bin(prev_gray_q);
  assign prev_inc = prev_bin + {{(WIDTH-1){1'b0}}, 1'b1};
  assign legal    = (popcount(bus.in_gray ^ prev_gray_q) == 5'd1);
  assign up       = (new_bin == prev_inc);

  // Next-state, lock tracking and output-slot update.
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    prev_gray_d = prev_gray_q;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    step_err_d  = step_err_q;
    dir_d       = dir_q;
    err_count_d = err_count_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_bin_d   = new_bin;
      prev_gray_d = bus.in_gray;
      case (state_q)
        ST_EMPTY: begin
          // Nothing to compare against: first sample is never an error.
          state_d    = ST_RESYNC;
          good_d     = 1'b0;
          step_err_d = 1'b0;
          dir_d      = 1'b0;
        end
        ST_RESYNC, ST_TRACK: begin
          if (legal) begin
            step_err_d = 1'b0;
            dir_d      = up;
            if (state_q == ST_RESYNC) begin
              if (good_q) begin
                state_d = ST_TRACK;
                good_d  = 1'b0;
              end else begin
                good_d  = 1'b1;
              end
            end
          end else begin
            state_d    = ST_RESYNC;
            good_d     = 1'b0;
            step_err_d = 1'b1;
            dir_d      = 1'b0;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = ST_EMPTY;
          good_d  = 1'b0;
        end
      endcase
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      good_q      <= 1'b0;
      prev_gray_q <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      step_err_q  <= 1'b0;
      dir_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      prev_gray_q <= prev_gray_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      step_err_q  <= step_err_d;
      dir_q       <= dir_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.step_err  = step_err_q;
  assign bus.dir       = dir_q;
  assign bus.locked    = (state_q == ST_TRACK);
  assign bus.err_count = err_count_q;

endmodule

// File: doc/gray_stream_decoder.md
GRAY_STREAM_DECODER -- requirements
Module: gray_stream_decoder

Interface
REQ-001 Parameter WIDTH SHALL default to 4 and set the code width; legal range 2..16.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit, asynchronous, active-low reset.
REQ-004 Port in_valid SHALL be an input, 1 bit, marking a Gray code present on in_gray.
REQ-005 Port in_gray SHALL be an input, WIDTH bits, the Gray-coded sample.
REQ-006 Port in_ready SHALL be an output, 1 bit, high when a sample can be accepted.
REQ-007 Port out_valid SHALL be an output, 1 bit, marking a decoded result.
REQ-008 Port out_ready SHALL be an input, 1 bit, the downstream accept.
REQ-009 Port out_bin SHALL be an output, WIDTH bits, the binary equivalent of the accepted code.
REQ-010 Port step_err SHALL be an output, 1 bit, qualified by out_valid, flagging an illegal Gray step.
REQ-011 Port dir SHALL be an output, 1 bit, qualified by out_valid and step_err=0: 1 = count up, 0 = count down.
REQ-012 Port locked SHALL be an output, 1 bit, high while the state is TRACK.
REQ-013 Port err_count SHALL be an output, 8 bits, the saturating count of illegal steps.

Function
REQ-014 Acceptance SHALL occur in a cycle where in_valid=1 and in_ready=1; in_ready SHALL equal (!out_valid || out_ready), combinational.
REQ-015 Decode: out_bin[WIDTH-1]=g[WIDTH-1]; out_bin[i]=out_bin[i+1]^g[i] for i<WIDTH-1.
REQ-016 Latency SHALL be 1 cycle: a sample accepted at edge N SHALL appear with out_valid=1 after edge N.
REQ-017 While out_valid=1 and out_ready=0, out_bin, step_err and dir SHALL hold stable.
REQ-018 Simultaneous out_ready=1 and new acceptance SHALL replace the output with no bubble; with out_ready=1 and no acceptance, out_valid SHALL drop.
REQ-019 A step SHALL be legal when the Hamming distance between the accepted code and the previous accepted code is exactly 1; distance 0 (repeat) or >=2 SHALL be illegal.
REQ-020 dir SHALL be 1 when new_bin == (prev_bin+1) mod 2^WIDTH, otherwise 0; wrap-around (e.g. 1000->0000 for WIDTH=4) SHALL be legal with dir=1.
REQ-021 States: EMPTY (no previous code), RESYNC (previous held, good-step count 0/1), TRACK.
REQ-022 EMPTY: first acceptance -> RESYNC with count 0; that output SHALL have step_err=0, dir=0.
REQ-023 RESYNC: legal step increments count; second consecutive legal step -> TRACK; illegal step -> count 0, stay RESYNC.
REQ-024 TRACK: legal step stays TRACK; illegal step -> RESYNC with count 0.
REQ-025 Every illegal step in RESYNC or TRACK SHALL assert step_err with its output and increment err_count once, saturating at 255.
REQ-026 The previous code SHALL update on every acceptance, legal or not.

Reset
REQ-027 rst_n=0 SHALL, immediately and regardless of clk, force state EMPTY, out_valid=0, out_bin=0, step_err=0, dir=0, locked=0, err_count=0 and clear the previous code.
REQ-028 Reset mid-stream SHALL discard any pending output; the first acceptance after release SHALL behave as from EMPTY.

Verification
REQ-029 Gray 0000,0001,0011,0010 with out_ready=1 -> out_bin 0,1,2,3 one cycle after each; step_err=0; locked=1 from the third output onward.
REQ-030 Locked, code 1000 (bin 15) then 0000 -> out_bin 0, dir=1, step_err=0; then 1000 -> out_bin 15, dir=0.
REQ-031 Locked, 0011 then 0110 (distance 2) -> step_err=1, err_count +1, locked=0; next two legal steps -> locked=1.
REQ-032 Locked, 0101 repeated -> step_err=1 on second; out_ready=0 for 3 cycles -> in_ready=0, output stable, no sample lost.
REQ-033 256 consecutive illegal steps -> err_count=255 and holds.
REQ-034 rst_n pulsed low between clk edges mid-stream -> all outputs 0 immediately; next code 0111 -> out_bin 5, step_err=0, locked=0.
